dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between requester 0 (the core load/store unit) and requester 1 (the debug/DMA port). It accepts one word access per cycle and drives the memory's address, enable and write-data inputs. It merges byte strobes into a read-modify-write within the same cycle, using the memory's combinational read path. It returns registered read data and an error flag one cycle after acceptance.

## Interface
- `ADDR_BITS`, default 10: byte-address width of the memory (1 KB); in-range means `addr[31:ADDR_BITS]==0`.
- `FIXED_PRIO`, default 0: 0 = round-robin; 1 = requester 0 always wins.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mN_req_valid` in 1 (N=0,1): request present.
- `mN_req_ready` out 1: request accepted this cycle.
- `mN_req_we` in 1: 1 = store, 0 = load.
- `mN_req_addr` in 32: byte address; must be word-aligned.
- `mN_req_wdata` in 32: store data.
- `mN_req_wstrb` in 4: byte enables for stores; bit i covers `wdata[8i+7:8i]`.
- `mN_rsp_valid` out 1: response pulse, one cycle.
- `mN_rsp_rdata` out 32: load data, or the pre-write word for stores.
- `mN_rsp_err` out 1: access rejected (misaligned or out of range).
- `mem_addr` out 32: to memory `addr`.
- `mem_write_enable` out 1: to memory `write_enable`.
- `mem_read_enable` out 1: to memory `read_enable`.
- `mem_write_data` out 32: to memory `write_data`.
- `mem_read_data` in 32: from memory `read_data`; combinational.

## Operation
- **Grant selection** (combinational, each cycle):
  - Only one requester valid: that requester is granted.
  - Both valid, `FIXED_PRIO=0`: grant goes to the requester not in `last_grant`.
  - Both valid, `FIXED_PRIO=1`: m0 is granted.
- **Handshake:**
  - `mN_req_ready = mN_req_valid & grant_N`. Acceptance is `valid & ready`.
  - A requester must hold valid and all request fields stable until ready.
- **`last_grant` register:** updates to the accepted requester on each acceptance; holds on idle cycles.
- **Access checks:** `err = (addr[1:0]!=0) | (addr[31:ADDR_BITS]!=0)`.
- **Memory drive during an acceptance:**
  - `mem_addr` = granted address.
  - `mem_read_enable` = 1.
  - `mem_write_enable = we & |wstrb & ~err`.
  - `mem_write_data[8i+7:8i]` = `wstrb[i]` ? `wdata` byte : `mem_read_data` byte.
- **Idle cycle:**
  - `mem_read_enable=0`, `mem_write_enable=0`.
  - `mem_addr` and `mem_write_data` = 0.
- **Response register** (granted requester only; the other requester's rsp_valid=0):
  - `rsp_valid` = 1.
  - `rsp_err` = err.
  - `rsp_rdata` = err ? 0 : `mem_read_data` sampled at the accept edge.
- **Store with `wstrb=0`:** no memory write; response carries err=0 plus the current word.
- **No response backpressure:** a requester must consume the response in its valid cycle.

## Timing
- **Accept cycle T:** response valid during cycle T+1; the store takes effect at the T edge.
- **Throughput:** one acceptance per cycle in total. Back-to-back accepts from the same requester are allowed.
- **Same address, consecutive cycles:**
  - A load at T+1 returns data written at T.
  - A load at T returns the pre-write value.
- **Round-robin fairness:** with both requesters continuously valid, grants alternate m0, m1, m0, …. Maximum wait is 1 cycle.
- **Reset values** (asynchronous assert):
  - All `rsp_valid`, `rsp_err`, `rsp_rdata` = 0.
  - `last_grant` = 1, so m0 wins the first contention.
- **While `rst_n`=0:**
  - `mem_write_enable`, `mem_read_enable` and both `req_ready` are forced 0, so no memory write occurs.
- **Reset mid-operation:** a response due in the cycle after reset assertion is dropped. Its store has already committed, or was blocked if reset was asserted before the edge.
- **Reset release:** first acceptance is possible in the first cycle after deassertion.

## Test plan
- **Reset:** assert `rst_n`=0 mid-traffic → all rsp outputs 0, `mem_write_enable`=0. After release, both requesters valid → m0 granted first.
- **Full-word store then load:**
  - m0 stores 0xDEADBEEF to 0x10, wstrb=4'hF.
  - m0 loads 0x10 next cycle → `m0_rsp_rdata`=0xDEADBEEF at T+2, err=0.
- **Byte merge:**
  - Word 0x20 holds 0x11223344.
  - m1 stores 0xAABBCCDD, wstrb=4'b0101 → memory becomes 0x11BB33DD; m1 store response rdata=0x11223344.
- **Contention:** both requesters valid for 6 cycles with `FIXED_PRIO=0` → grants m0,m1,m0,m1,m0,m1; exactly one `rsp_valid` per cycle.
  - Repeat with `FIXED_PRIO=1` → m0 granted all 6 cycles, m1 ready stays 0.
- **Errors, no memory write:**
  - Store to 0x13 → err=1, rdata=0.
  - Store to 0x400 → err=1, rdata=0.
- **Read-after-write ordering:**
  - m1 stores 0x5 to 0x30 at cycle T; m0 loads 0x30 at T+1 → m0 gets 0x5.
  - m0 load of 0x30 in the same cycle is deferred by arbitration and also returns 0x5.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-ported data memory between two requesters:
//   m0 = core load/store unit, m1 = debug/DMA port.
// One word access is accepted per cycle. Partial stores are merged into a
// read-modify-write in the same cycle, using the memory's combinational read
// path. The response (read data plus error flag) is registered and appears
// one cycle after acceptance.
//
// Parameters
//   ADDR_BITS   byte-address width of the memory; in range when
//               addr[31:ADDR_BITS] == 0
//   FIXED_PRIO  0 = round-robin between m0/m1, 1 = m0 always wins
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   mN_req_valid/ready         request handshake (N = 0, 1)
//   mN_req_we/addr/wdata/wstrb request fields (store flag, byte address,
//                              store data, byte enables)
//   mN_rsp_valid/rdata/err     one-cycle response pulse, read data (pre-write
//                              word for stores), access error
//   mem_addr/write_enable/read_enable/write_data/read_data
//                              memory interface; read_data is combinational
//
// Handshake: a request is accepted in a cycle where valid & ready are both 1.
// ready is never asserted without valid. Once valid is raised the requester
// holds valid and every request field stable until ready. Responses cannot be
// stalled: the requester must take rsp_* in the single cycle rsp_valid is 1.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_BITS  = 10,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic        m0_req_we,
    input  logic [31:0] m0_req_addr,
    input  logic [31:0] m0_req_wdata,
    input  logic [3:0]  m0_req_wstrb,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_err,

    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic        m1_req_we,
    input  logic [31:0] m1_req_addr,
    input  logic [31:0] m1_req_wdata,
    input  logic [3:0]  m1_req_wstrb,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_err,

    output logic [31:0] mem_addr,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    // Requester that won the most recent acceptance (0 = m0, 1 = m1).
    logic        last_grant;

    logic        grant0;
    logic        grant1;
    logic        accept;
    logic        sel;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    logic        err;
    logic [31:0] merged;

    // Grant selection. Grants are gated by rst_n so nothing is accepted
    // (and no memory write happens) while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            if (m0_req_valid && m1_req_valid) begin
                // Round-robin: m0 wins when m1 had the last grant.
                if (FIXED_PRIO || last_grant) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = m0_req_valid;
                grant1 = m1_req_valid;
            end
        end
    end

    assign m0_req_ready = grant0;
    assign m1_req_ready = grant1;
    assign accept       = grant0 | grant1;
    assign sel          = grant1;

    // Granted request fields.
    assign sel_we    = sel ? m1_req_we    : m0_req_we;
    assign sel_addr  = sel ? m1_req_addr  : m0_req_addr;
    assign sel_wdata = sel ? m1_req_wdata : m0_req_wdata;
    assign sel_wstrb = sel ? m1_req_wstrb : m0_req_wstrb;

    assign err = (sel_addr[1:0] != 2'b00) | (sel_addr[31:ADDR_BITS] != '0);

    // Read-modify-write merge: enabled bytes come from the store data, the
    // rest from the word currently in memory at the same address.
    always_comb begin
        merged = '0;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = sel_wstrb[i] ? sel_wdata[8*i +: 8]
                                            : mem_read_data[8*i +: 8];
        end
    end

    assign mem_addr         = accept ? sel_addr : 32'h0;
    assign mem_read_enable  = accept;
    assign mem_write_enable = accept & sel_we & (|sel_wstrb) & ~err;
    assign mem_write_data   = accept ? merged : 32'h0;

    // Arbitration state and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant   <= 1'b1;
            m0_rsp_valid <= 1'b0;
            m0_rsp_err   <= 1'b0;
            m0_rsp_rdata <= 32'h0;
            m1_rsp_valid <= 1'b0;
            m1_rsp_err   <= 1'b0;
            m1_rsp_rdata <= 32'h0;
        end else begin
            if (accept) begin
                last_grant <= sel;
            end
            // Non-granted side is cleared so each response is a clean pulse.
            m0_rsp_valid <= grant0;
            m0_rsp_err   <= grant0 & err;
            m0_rsp_rdata <= (grant0 && !err) ? mem_read_data : 32'h0;
            m1_rsp_valid <= grant1;
            m1_rsp_err   <= grant1 & err;
            m1_rsp_rdata <= (grant1 && !err) ? mem_read_data : 32'h0;
        end
    end

endmodule
